// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the alu_mdu execute-stage unit.
//   - 6-bit opcode encodings, kept identical to the legacy MIPS decoder
//   - sequencer state type (IDLE / MUL / DIV / DONE)
//   - small opcode classification helpers used by the top and the bench
package alu_pkg;

  localparam logic [5:0] OP_ADD   = 6'd27;
  localparam logic [5:0] OP_SUB   = 6'd28;
  localparam logic [5:0] OP_SRL   = 6'd29;
  localparam logic [5:0] OP_SLL   = 6'd30;
  localparam logic [5:0] OP_XOR   = 6'd31;
  localparam logic [5:0] OP_AND   = 6'd32;
  localparam logic [5:0] OP_OR    = 6'd33;
  localparam logic [5:0] OP_NOR   = 6'd34;
  localparam logic [5:0] OP_SLT   = 6'd35;
  localparam logic [5:0] OP_SLTU  = 6'd36;
  localparam logic [5:0] OP_SRA   = 6'd37;
  localparam logic [5:0] OP_MULT  = 6'd38;
  localparam logic [5:0] OP_MULTU = 6'd39;
  localparam logic [5:0] OP_DIV   = 6'd40;
  localparam logic [5:0] OP_DIVU  = 6'd41;
  localparam logic [5:0] OP_MFHI  = 6'd42;
  localparam logic [5:0] OP_MFLO  = 6'd43;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_e;

  // Opcodes that run on the iterative multiply/divide unit.
  function automatic logic is_mdu_op(input logic [5:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic is_div_op(input logic [5:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic is_signed_mdu_op(input logic [5:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/mdu_iter.sv
// mdu_iter: iterative multiply / divide datapath, one result bit per cycle.
//   Multiply is shift-add on magnitudes; divide is restoring division on
//   magnitudes. Signs are captured at start and applied by a combinational
//   fix-up, so res_hi/res_lo are final once the last step has been taken.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   start           load operands (one-cycle pulse on accept of an MDU op)
//   is_div          1 = divide, 0 = multiply (sampled on start)
//   is_signed       signed variant (sampled on start)
//   op_a, op_b      operand A (multiplicand / dividend), operand B
//   step            advance one iteration this cycle
//   last            this step is the final iteration (done pulse)
//   div0            divide by zero was detected at start
//   res_hi, res_lo  signed-corrected HI (product upper / remainder) and
//                   LO (product lower / quotient)
module mdu_iter #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_div,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             step,
  output logic             last,
  output logic             div0,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo
);

  // acc_hi: partial product upper half / running remainder
  // acc_lo: multiplier being consumed LSB-first / dividend shifting out MSB-first,
  //         with quotient bits shifting in
  // opnd  : multiplicand magnitude / divisor magnitude
  logic [WIDTH-1:0]   acc_hi;
  logic [WIDTH-1:0]   acc_lo;
  logic [WIDTH-1:0]   opnd;
  logic [SHW-1:0]     cnt;
  logic               neg_a;
  logic               neg_b;
  logic               div_mode;

  logic               sgn_a;
  logic               sgn_b;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     rem_sh;
  logic               fits;
  logic [WIDTH-1:0]   hi_next;
  logic [WIDTH-1:0]   lo_next;

  logic               neg_q;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_fix;

  assign sgn_a = is_signed & op_a[WIDTH-1];
  assign sgn_b = is_signed & op_b[WIDTH-1];
  // Magnitude of the most negative value wraps to itself, which is the
  // correct unsigned magnitude 2^(WIDTH-1).
  assign mag_a = sgn_a ? -op_a : op_a;
  assign mag_b = sgn_b ? -op_b : op_b;

  assign last = step && (cnt == '0);

  // One iteration of either algorithm.
  always_comb begin
    mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
    rem_sh  = {acc_hi, acc_lo[WIDTH-1]};
    fits    = (rem_sh >= {1'b0, opnd});
    hi_next = '0;
    lo_next = '0;
    if (div_mode) begin
      // The remainder after subtraction is always below the divisor, so the
      // low WIDTH bits of the difference are exact.
      hi_next = fits ? (rem_sh[WIDTH-1:0] - opnd) : rem_sh[WIDTH-1:0];
      lo_next = {acc_lo[WIDTH-2:0], fits};
    end else begin
      hi_next = mul_sum[WIDTH:1];
      lo_next = {mul_sum[0], acc_lo[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_hi   <= '0;
      acc_lo   <= '0;
      opnd     <= '0;
      cnt      <= '0;
      neg_a    <= 1'b0;
      neg_b    <= 1'b0;
      div_mode <= 1'b0;
      div0     <= 1'b0;
    end else if (start) begin
      neg_a    <= sgn_a;
      neg_b    <= sgn_b;
      div_mode <= is_div;
      cnt      <= SHW'(WIDTH - 1);
      div0     <= is_div && (op_b == '0);
      if (is_div && (op_b == '0)) begin
        // No iteration: the architectural answer is loaded directly.
        acc_hi <= op_a;
        acc_lo <= '1;
        opnd   <= op_b;
      end else if (is_div) begin
        acc_hi <= '0;
        acc_lo <= mag_a;
        opnd   <= mag_b;
      end else begin
        acc_hi <= '0;
        acc_lo <= mag_b;
        opnd   <= mag_a;
      end
    end else if (step) begin
      cnt    <= cnt - 1'b1;
      acc_hi <= hi_next;
      acc_lo <= lo_next;
    end
  end

  // Sign fix-up. Quotient sign is the XOR of operand signs; the remainder
  // follows the dividend. MIN / -1 falls out naturally: quotient magnitude
  // 2^(WIDTH-1) with positive sign reads back as MIN, remainder 0.
  always_comb begin
    neg_q    = neg_a ^ neg_b;
    prod     = {acc_hi, acc_lo};
    prod_fix = neg_q ? -prod : prod;
    res_hi   = prod_fix[2*WIDTH-1:WIDTH];
    res_lo   = prod_fix[WIDTH-1:0];
    if (div0) begin
      res_hi = acc_hi;
      res_lo = acc_lo;
    end else if (div_mode) begin
      res_lo = neg_q ? -acc_lo : acc_lo;
      res_hi = neg_a ? -acc_hi : acc_hi;
    end
  end

endmodule

// File: rtl/alu_mdu.sv
// alu_mdu: execute-stage ALU with registered output plus an iterative
// multiply/divide unit that owns HI/LO.
//
// Handshake: a request transfers when in_valid && in_ready; a result
// transfers when out_valid && out_ready. The output register holds result
// and flags unchanged while out_valid && !out_ready. in_ready is high only
// in IDLE with the output register free or being drained this cycle.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   in_valid/in_ready request handshake
//   operation         6-bit opcode (alu_pkg encoding)
//   source1, source2  operands A and B
//   shamt             shift amount (shifts use this, never B)
//   out_valid/out_ready result handshake
//   result            registered result
//   zero              registered result equals zero
//   carry             ADD carry-out / SUB borrow, else 0
//   overflow          ADD/SUB signed overflow, else 0
//   div_by_zero       DIV/DIVU with B == 0
//   illegal_op        unrecognised opcode (result forced to 0)
module alu_mdu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       operation,
  input  logic [WIDTH-1:0] source1,
  input  logic [WIDTH-1:0] source2,
  input  logic [SHW-1:0]   shamt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry,
  output logic             overflow,
  output logic             div_by_zero,
  output logic             illegal_op
);

  state_e           state;
  state_e           state_next;

  logic             accept;
  logic             out_fire;
  logic             mdu_accept;
  logic             alu_accept;
  logic             div_zero_req;

  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;

  logic             mdu_step;
  logic             mdu_last;
  logic             mdu_div0;
  logic [WIDTH-1:0] mdu_hi;
  logic [WIDTH-1:0] mdu_lo;

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] alu_res;
  logic             alu_carry;
  logic             alu_ovf;
  logic             alu_ill;

  assign in_ready     = (state == IDLE) && (!out_valid || out_ready);
  assign accept       = in_valid && in_ready;
  assign out_fire     = out_valid && out_ready;
  assign mdu_accept   = accept && is_mdu_op(operation);
  assign alu_accept   = accept && !is_mdu_op(operation);
  assign div_zero_req = is_div_op(operation) && (source2 == '0);
  assign mdu_step     = (state == MUL) || (state == DIV);

  // ---------------------------------------------------------------------
  // Sequencer: IDLE -> MUL/DIV -> DONE -> IDLE
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (mdu_accept) begin
          if (div_zero_req) begin
            state_next = DONE;
          end else if (is_div_op(operation)) begin
            state_next = DIV;
          end else begin
            state_next = MUL;
          end
        end
      end
      MUL, DIV: begin
        if (mdu_last) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  mdu_iter #(
    .WIDTH (WIDTH),
    .SHW   (SHW)
  ) u_mdu (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (mdu_accept),
    .is_div    (is_div_op(operation)),
    .is_signed (is_signed_mdu_op(operation)),
    .op_a      (source1),
    .op_b      (source2),
    .step      (mdu_step),
    .last      (mdu_last),
    .div0      (mdu_div0),
    .res_hi    (mdu_hi),
    .res_lo    (mdu_lo)
  );

  // ---------------------------------------------------------------------
  // Single-cycle ALU
  // ---------------------------------------------------------------------
  assign sum  = {1'b0, source1} + {1'b0, source2};
  // Top bit of the widened difference is the unsigned borrow (A < B).
  assign diff = {1'b0, source1} - {1'b0, source2};

  always_comb begin
    alu_res   = '0;
    alu_carry = 1'b0;
    alu_ovf   = 1'b0;
    alu_ill   = 1'b0;
    case (operation)
      OP_ADD: begin
        alu_res   = sum[WIDTH-1:0];
        alu_carry = sum[WIDTH];
        alu_ovf   = (source1[WIDTH-1] == source2[WIDTH-1]) &&
                    (sum[WIDTH-1] != source1[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res   = diff[WIDTH-1:0];
        alu_carry = diff[WIDTH];
        alu_ovf   = (source1[WIDTH-1] != source2[WIDTH-1]) &&
                    (diff[WIDTH-1] != source1[WIDTH-1]);
      end
      OP_SRL:  alu_res = source1 >> shamt;
      OP_SLL:  alu_res = source1 << shamt;
      OP_SRA:  alu_res = $unsigned($signed(source1) >>> shamt);
      OP_XOR:  alu_res = source1 ^ source2;
      OP_AND:  alu_res = source1 & source2;
      OP_OR:   alu_res = source1 | source2;
      OP_NOR:  alu_res = ~(source1 | source2);
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(source1) < $signed(source2))};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (source1 < source2)};
      OP_MFHI: alu_res = hi_q;
      OP_MFLO: alu_res = lo_q;
      OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: alu_res = '0;
      default: alu_ill = 1'b1;
    endcase
  end

  // ---------------------------------------------------------------------
  // Output register and HI/LO. HI/LO are written only in DONE. The output
  // register is guaranteed free in DONE because an MDU op is accepted only
  // when the previous result has left or is leaving.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      result      <= '0;
      zero        <= 1'b0;
      carry       <= 1'b0;
      overflow    <= 1'b0;
      div_by_zero <= 1'b0;
      illegal_op  <= 1'b0;
      hi_q        <= '0;
      lo_q        <= '0;
    end else if (state == DONE) begin
      hi_q        <= mdu_hi;
      lo_q        <= mdu_lo;
      out_valid   <= 1'b1;
      result      <= mdu_lo;
      zero        <= (mdu_lo == '0);
      carry       <= 1'b0;
      overflow    <= 1'b0;
      div_by_zero <= mdu_div0;
      illegal_op  <= 1'b0;
    end else if (alu_accept) begin
      out_valid   <= 1'b1;
      result      <= alu_res;
      zero        <= (alu_res == '0);
      carry       <= alu_carry;
      overflow    <= alu_ovf;
      div_by_zero <= 1'b0;
      illegal_op  <= alu_ill;
    end else if (out_fire) begin
      out_valid   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_mdu.sv
// tb_alu_mdu: scoreboard bench for alu_mdu (WIDTH = 32).
// Driver tasks push expected responses at issue time; an independent monitor
// pops and compares whenever a result transfers. Randomised traffic is
// checked against an arithmetic reference model; directed cases use literal
// expected values.
module tb_alu_mdu;
  import alu_pkg::*;

  localparam int W  = 32;
  localparam int SW = 5;
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [5:0]    operation;
  logic [W-1:0]  source1;
  logic [W-1:0]  source2;
  logic [SW-1:0] shamt;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  result;
  logic          zero;
  logic          carry;
  logic          overflow;
  logic          div_by_zero;
  logic          illegal_op;

  int n_checks = 0;
  int n_pass   = 0;
  int bp_mode  = 0;   // 0: out_ready=1, 1: random, 2: held low

  logic [W-1:0] exp_q[$];
  logic [4:0]   exp_f_q[$];   // {zero, carry, overflow, div_by_zero, illegal_op}
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;

  alu_mdu #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .operation   (operation),
    .source1     (source1),
    .source2     (source2),
    .shamt       (shamt),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .zero        (zero),
    .carry       (carry),
    .overflow    (overflow),
    .div_by_zero (div_by_zero),
    .illegal_op  (illegal_op)
  );

  // ---------------- clock / reset-independent drivers ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (bp_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b0;
      endcase
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Reference model: plain arithmetic on 64-bit integers.
  task automatic model(input logic [5:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [SW-1:0] sh, output logic [W-1:0] res, output logic [4:0] fl);
    longint sa, sb, s;
    logic [63:0] p;
    logic c, ov, dz, ill;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    c = 1'b0; ov = 1'b0; dz = 1'b0; ill = 1'b0; res = '0;
    case (op)
      OP_ADD:  begin p = 64'(a) + 64'(b); res = p[31:0]; c = p[32];
                     s = sa + sb; ov = (s > SMAX) || (s < SMIN); end
      OP_SUB:  begin res = a - b; c = (a < b); s = sa - sb; ov = (s > SMAX) || (s < SMIN); end
      OP_SRL:  res = a >> sh;
      OP_SLL:  res = a << sh;
      OP_SRA:  begin s = sa >>> sh; p = s; res = p[31:0]; end
      OP_XOR:  res = a ^ b;
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_NOR:  res = ~(a | b);
      OP_SLT:  res = (sa < sb) ? 32'd1 : 32'd0;
      OP_SLTU: res = (a < b) ? 32'd1 : 32'd0;
      OP_MULT: begin s = sa * sb; p = s; m_hi = p[63:32]; m_lo = p[31:0]; res = m_lo; end
      OP_MULTU: begin p = 64'(a) * 64'(b); m_hi = p[63:32]; m_lo = p[31:0]; res = m_lo; end
      OP_DIV: begin
        if (b == '0) begin m_lo = '1; m_hi = a; dz = 1'b1; end
        else begin s = sa / sb; p = s; m_lo = p[31:0]; s = sa % sb; p = s; m_hi = p[31:0]; end
        res = m_lo;
      end
      OP_DIVU: begin
        if (b == '0) begin m_lo = '1; m_hi = a; dz = 1'b1; end
        else begin m_lo = a / b; m_hi = a % b; end
        res = m_lo;
      end
      OP_MFHI: res = m_hi;
      OP_MFLO: res = m_lo;
      default: ill = 1'b1;
    endcase
    fl = {(res == '0), c, ov, dz, ill};
  endtask

  // ---------------- driver ----------------
  task automatic issue(input logic [5:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [SW-1:0] sh, input bit use_exp,
                       input logic [W-1:0] e_res, input logic [4:0] e_fl);
    int waited;
    logic [W-1:0] r;
    logic [4:0] f;
    @(negedge clk);
    operation = op; source1 = a; source2 = b; shamt = sh; in_valid = 1'b1;
    waited = 0;
    while (!in_ready && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    check("accept_in_time", 64'(in_ready), 64'd1);
    if (!in_ready) begin
      in_valid = 1'b0;
      return;
    end
    model(op, a, b, sh, r, f);
    if (use_exp) begin
      r = e_res;
      f = e_fl;
    end
    exp_q.push_back(r);
    exp_f_q.push_back(f);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic dir(input logic [5:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic [SW-1:0] sh, input logic [W-1:0] e_res, input logic [4:0] e_fl);
    issue(op, a, b, sh, 1'b1, e_res, e_fl);
  endtask

  task automatic drain();
    int cnt;
    cnt = 0;
    while (exp_q.size() != 0 && cnt < 500) begin
      @(negedge clk);
      cnt++;
    end
    check("drain_outstanding", 64'(exp_q.size()), 64'd0);
  endtask

  function automatic logic [W-1:0] rnd_val();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'h0000_0001;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [W-1:0] e_r;
    logic [4:0]   e_f;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", 64'(out_valid), 64'd0);
        end else begin
          e_r = exp_q.pop_front();
          e_f = exp_f_q.pop_front();
          check("result", 64'(result), 64'(e_r));
          check("flags", 64'({zero, carry, overflow, div_by_zero, illegal_op}), 64'(e_f));
        end
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [5:0] ops[20];
    int k;
    logic ir_seen;
    ops = '{OP_ADD, OP_SUB, OP_SRL, OP_SLL, OP_XOR, OP_AND, OP_OR, OP_NOR, OP_SLT, OP_SLTU,
            OP_SRA, OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MFHI, OP_MFLO, 6'd63, 6'd0, 6'd44};
    rst_n = 1'b0; in_valid = 1'b0; operation = '0; source1 = '0; source2 = '0; shamt = '0;

    repeat (3) @(negedge clk);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_result", 64'(result), 64'd0);
    check("reset_flags", 64'({zero, carry, overflow, div_by_zero, illegal_op}), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_in_ready", 64'(in_ready), 64'd1);
    check("post_reset_out_valid", 64'(out_valid), 64'd0);

    // Directed arithmetic corners.
    dir(OP_ADD,  32'hFFFF_FFFF, 32'd1, 0, 32'h0000_0000, 5'b11000);
    dir(OP_ADD,  32'h7FFF_FFFF, 32'd1, 0, 32'h8000_0000, 5'b00100);
    dir(OP_SUB,  32'd3,         32'd5, 0, 32'hFFFF_FFFE, 5'b01000);
    dir(OP_SUB,  32'h8000_0000, 32'd1, 0, 32'h7FFF_FFFF, 5'b00100);
    dir(OP_SRA,  32'h8000_0000, 32'h1234_5678, 5'd4, 32'hF800_0000, 5'b00000);
    dir(OP_SRL,  32'h8000_0000, 32'd0, 5'd4, 32'h0800_0000, 5'b00000);
    dir(OP_SLL,  32'h0000_0003, 32'd0, 5'd31, 32'h8000_0000, 5'b00000);
    dir(OP_SLT,  32'hFFFF_FFFF, 32'd1, 0, 32'd1, 5'b00000);
    dir(OP_SLTU, 32'hFFFF_FFFF, 32'd1, 0, 32'd0, 5'b10000);
    dir(OP_NOR,  32'h0F0F_0000, 32'h00F0_0000, 0, 32'hF000_FFFF, 5'b00000);

    // MULT latency and in_ready low throughout.
    dir(OP_MULT, 32'hFFFF_FFFD, 32'd7, 0, 32'hFFFF_FFEB, 5'b00000);
    k = 0;
    ir_seen = 1'b0;
    @(negedge clk);
    while (!out_valid && k < 100) begin
      if (in_ready) ir_seen = 1'b1;
      @(negedge clk);
      k++;
    end
    check("mult_latency", 64'(k), 64'd33);
    check("mult_in_ready_low", 64'(ir_seen), 64'd0);
    dir(OP_MFHI, 0, 0, 0, 32'hFFFF_FFFF, 5'b00000);
    dir(OP_MFLO, 0, 0, 0, 32'hFFFF_FFEB, 5'b00000);

    dir(OP_DIV,  32'hFFFF_FFF9, 32'd2, 0, 32'hFFFF_FFFD, 5'b00000);
    dir(OP_MFHI, 0, 0, 0, 32'hFFFF_FFFF, 5'b00000);
    dir(OP_DIVU, 32'd7, 32'd0, 0, 32'hFFFF_FFFF, 5'b00010);
    dir(OP_MFHI, 0, 0, 0, 32'd7, 5'b00000);
    dir(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 0, 32'h8000_0000, 5'b00000);
    dir(OP_MFHI, 0, 0, 0, 32'd0, 5'b10000);
    dir(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 32'h0000_0001, 5'b00000);
    dir(OP_MFHI, 0, 0, 0, 32'hFFFF_FFFE, 5'b00000);
    dir(OP_DIVU, 32'd100, 32'd7, 0, 32'd14, 5'b00000);
    dir(OP_MFHI, 0, 0, 0, 32'd2, 5'b00000);
    dir(6'd63,   32'h1234_5678, 32'd9, 0, 32'd0, 5'b10001);
    drain();

    // Backpressure: result and flags must hold while out_ready is low.
    bp_mode = 2;
    @(posedge clk);
    #2;
    dir(OP_ADD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 32'hFFFF_FFFE, 5'b01000);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_out_valid", 64'(out_valid), 64'd1);
      check("bp_hold_result", 64'(result), 64'hFFFF_FFFE);
      check("bp_hold_flags", 64'({zero, carry, overflow, div_by_zero, illegal_op}), 64'b01000);
      check("bp_in_ready_low", 64'(in_ready), 64'd0);
    end
    bp_mode = 0;
    @(posedge clk);
    #2;
    @(negedge clk);
    check("bp_release_out_valid", 64'(out_valid), 64'd1);
    check("bp_release_in_ready", 64'(in_ready), 64'd1);
    drain();

    // Asynchronous reset in the middle of a divide.
    dir(OP_DIV, 32'd1000, 32'd7, 0, 32'd142, 5'b00000);
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", 64'(out_valid), 64'd0);
    check("abort_result", 64'(result), 64'd0);
    exp_q.delete();
    exp_f_q.delete();
    m_hi = '0;
    m_lo = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_in_ready", 64'(in_ready), 64'd1);
    dir(OP_MFHI, 0, 0, 0, 32'd0, 5'b10000);
    dir(OP_MFLO, 0, 0, 0, 32'd0, 5'b10000);
    drain();

    // Randomised traffic against the reference model with random backpressure.
    bp_mode = 1;
    for (int n = 0; n < 250; n++) begin
      logic [W-1:0] a, b;
      a = rnd_val();
      b = rnd_val();
      issue(ops[$urandom_range(0, 19)], a, b, SW'($urandom_range(0, 31)), 1'b0, '0, '0);
    end
    bp_mode = 0;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_mdu.md
Name: alu_mdu

Overview:
- Parametrised successor to the datapath ALU in the MIPS core: a WIDTH-bit ALU with registered output, plus an iterative multiply/divide unit (MDU) that owns the HI/LO registers.
- Sits in EX: the decoder issues (op, A, B, shamt) on a valid/ready handshake; results return on a registered valid/ready output.
- Single-cycle ops complete in 1 cycle. MULT/DIV stall the issue side for WIDTH+1 cycles.

Parameters:
- WIDTH, 32, operand/result width; must be ≥ 4 and a power of 2.
- SHW, $clog2(WIDTH), shamt width (derived; not overridden).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- in_valid  in  1  request valid
- in_ready  out  1  unit can accept a request this cycle
- operation  in  6  opcode, alu_pkg encoding
- source1  in  WIDTH  operand A
- source2  in  WIDTH  operand B
- shamt  in  SHW  shift amount
- out_valid  out  1  result valid
- out_ready  in  1  consumer takes the result
- result  out  WIDTH  result
- zero  out  1  result == 0
- carry  out  1  carry-out (ADD) or borrow (SUB); 0 for other ops
- overflow  out  1  signed overflow (ADD/SUB only)
- div_by_zero  out  1  DIV/DIVU with B == 0
- illegal_op  out  1  unrecognised opcode

Behaviour:
- Opcodes, existing codes kept:
  - 27 ADD, 28 SUB, 29 SRL, 30 SLL, 31 XOR, 32 AND
  - 33 OR, 34 NOR, 35 SLT, 36 SLTU, 37 SRA
  - 38 MULT, 39 MULTU, 40 DIV, 41 DIVU, 42 MFHI, 43 MFLO
- Handshake:
  - A request is accepted when in_valid && in_ready.
  - in_ready = (state == IDLE) && (!out_valid || out_ready).
  - A result is consumed when out_valid && out_ready.
  - result and all flags hold stable while out_valid && !out_ready.
- Reset: state = IDLE; out_valid, result, all flags, HI, LO = 0; in_ready = 1 once rst_n is high.
- Single-cycle ops (27–37, 42, 43, illegal): result is registered. out_valid rises the cycle after accept, so back-to-back throughput is 1/cycle when out_ready = 1.
- Arithmetic:
  - ADD: {carry,result} = A + B, computed WIDTH+1 wide.
  - SUB: {carry,result} = A − B, WIDTH+1 wide; carry = 1 iff A < B unsigned.
  - overflow is set on sign mismatch per standard two's-complement rules.
  - SLT/SLTU return 1 or 0, zero-extended.
  - SRA is arithmetic; SRL/SLL are logical. All shifts use shamt only; B is ignored.
  - Flags not defined for an op are 0.
- MFHI/MFLO return HI/LO.
- Illegal opcode: result = 0, illegal_op = 1, still completes in 1 cycle.
- State machine IDLE → MUL/DIV → DONE → IDLE:
  - Accepting 38/39 goes to MUL; accepting 40/41 goes to DIV, latching operands and signs.
  - MUL: shift-add, one bit per cycle, WIDTH cycles. Signed ops work on magnitudes, then sign-fix.
  - DIV: restoring divide, one bit per cycle, WIDTH cycles. The quotient sign is the XOR of the operand signs; the remainder takes the dividend's sign.
  - DONE: write HI/LO.
    - MUL: HI = product upper, LO = product lower.
    - DIV: LO = quotient, HI = remainder.
    - Assert out_valid with result = LO.
    - Return to IDLE at the end of DONE (or on the output handshake).
  - Latency from accept to out_valid is WIDTH+1 cycles.
  - in_ready = 0 throughout MUL/DIV/DONE.
- Divide by zero: no iteration. Go straight to DONE the next cycle with LO = all-ones, HI = dividend, div_by_zero = 1.
- Signed MIN / −1: LO = MIN, HI = 0, no error flag.
- zero is derived from the registered result.
- Asynchronous reset mid-MUL/DIV: abort; HI/LO are cleared and no result is produced.
- HI/LO change only in DONE.

Decomposition:
- alu_pkg holds: opcode localparams (OP_ADD=27 … OP_MFLO=43), the state enum (IDLE, MUL, DIV, DONE), and an is_mdu_op(op) function.
- Sub-module mdu_iter holds the iterative mul/div datapath: counter, accumulator, sign fix-up, start/done pulse.
- alu_mdu holds the combinational ALU, the handshake, and the output register.

Test Plan:
- ADD 0xFFFFFFFF + 1 with out_ready = 1 → next cycle result = 0, zero = 1, carry = 1, overflow = 0. Then ADD 0x7FFFFFFF + 1 → result 0x80000000, overflow = 1.
- SUB 3 − 5 → result 0xFFFFFFFE, carry = 1. SRA 0x80000000 by shamt 4 → 0xF8000000. SLT(−1, 1) → 1. SLTU(−1, 1) → 0.
- MULT −3 × 7 → out_valid exactly 33 cycles after accept, with in_ready = 0 throughout. LO = 0xFFFFFFEB, HI = 0xFFFFFFFF. MFHI then returns 0xFFFFFFFF.
- DIV −7 / 2 → LO = 0xFFFFFFFD, HI = 0xFFFFFFFF. DIVU 7 / 0 → after 2 cycles LO = 0xFFFFFFFF, HI = 7, div_by_zero = 1.
- Backpressure: hold out_ready = 0 for 5 cycles after an ADD → result and flags stable, in_ready = 0. Release → the next request is accepted in the same cycle.
- Pull rst_n low mid-DIV (cycle 10) → out_valid = 0 and HI = LO = 0 immediately. Opcode 63 → result 0, illegal_op = 1.
